// File: rtl/calc1_port_responder.sv
// calc1_port_responder
//   DUT side of the calc1 command/operand protocol. A nonzero command is
//   taken together with operand 1. Operand 2 is taken on the next cycle.
//   The add/sub/shl/shr result and a response code are registered LATENCY
//   edges after the operand-2 sampling edge. They are held for one cycle
//   only.
//
// Handshake: there is no valid/ready pair. A command is accepted only on an
//   edge where busy_out is low and cmd_in is nonzero. While busy_out is high,
//   cmd_in is ignored; nothing is queued and no response is produced for it.
//   The response cycle already has busy_out low, so back-to-back commands
//   can be accepted.
//
// Ports:
//   c_clk    : clock, all logic on the rising edge
//   reset    : synchronous, active-high reset (aborts any command in flight)
//   cmd_in   : command (0 = no-op, 1 add, 2 sub, 5 shl, 6 shr, others invalid)
//   data_in  : operand 1 in the command cycle, operand 2 in the next cycle
//   data_out : result, nonzero only while resp_out != 0
//   resp_out : 0 none, 1 success, 2 overflow/underflow, 3 invalid command
//   busy_out : high while a command is in flight
module calc1_port_responder #(
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int LATENCY = 3   // 1..15
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:CMD_W-1]  cmd_in,
  input  logic [0:DATA_W-1] data_in,
  output logic [0:DATA_W-1] data_out,
  output logic [0:1]        resp_out,
  output logic              busy_out
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_SHL = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_SHR = CMD_W'(6);

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_OVF = 2'd2;
  localparam logic [1:0] RESP_INV = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic              take_cmd, take_op2, fire;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic [1:0]        code;

  // FSM next-state and control strobes
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take_cmd = 1'b0;
    take_op2 = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_in != '0) begin
          take_cmd = 1'b1;
          state_nx = OP2;
        end
      end
      OP2: begin
        // cmd_in is ignored here even if nonzero
        take_op2 = 1'b1;
        cnt_nx   = LAT_LOAD;
        state_nx = EXEC;
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          fire     = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Arithmetic on the latched operands. The sum is one bit wider so that the
  // carry out can be detected.
  always_comb begin
    sum    = {1'b0, op1_q} + {1'b0, op2_q};
    result = '0;
    code   = RESP_INV;
    case (cmd_q)
      CMD_ADD: begin
        if (sum[DATA_W]) begin
          code = RESP_OVF;
        end else begin
          code   = RESP_OK;
          result = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2_q > op1_q) begin
          code = RESP_OVF;
        end else begin
          code   = RESP_OK;
          result = op1_q - op2_q;
        end
      end
      CMD_SHL: begin
        code   = RESP_OK;
        result = op1_q << op2_q[SH_W-1:0];
      end
      CMD_SHR: begin
        code   = RESP_OK;
        result = op1_q >> op2_q[SH_W-1:0];
      end
      default: begin
        code   = RESP_INV;
        result = '0;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cmd_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      data_out <= '0;
      resp_out <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (take_cmd) begin
        cmd_q <= cmd_in;
        op1_q <= data_in;
      end
      if (take_op2) begin
        op2_q <= data_in;
      end
      // Outputs are zero except in the single response cycle.
      data_out <= fire ? result : '0;
      resp_out <= fire ? code   : 2'd0;
    end
  end

  assign busy_out = (state != IDLE);

endmodule

// File: doc/calc1_port_responder.md
Name: calc1_port_responder

Overview:
- Single-port calc1 responder, the DUT side of the calc1 command/operand protocol that our benches drive.
- Accepts a 4-bit command with operand 1, then operand 2 on the following cycle.
- Computes add, subtract, shift-left or shift-right.
- Returns a one-cycle response code with result data after a fixed latency.

Parameters:
DATA_W, 32, operand and result width
CMD_W, 4, command width
LATENCY, 3, clock edges from the operand-2 sampling edge to the response edge (legal range 1..15)

Ports:
c_clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd_in  input  [0:CMD_W-1]  command; 0 = no-op
data_in  input  [0:DATA_W-1]  operand 1 in the command cycle, operand 2 in the next cycle
data_out  output  [0:DATA_W-1]  result; valid only while resp_out != 0
resp_out  output  [0:1]  0 none, 1 success, 2 overflow/underflow, 3 invalid command
busy_out  output  1  high while a command is in flight; new commands ignored

Behaviour:
- Reset: one clock is synchronous and reset is synchronous, active-high.
  - Reset is sampled on c_clk rising edge and forces data_out=0, resp_out=0, busy_out=0, state=IDLE, latency counter=0.
  - Reset during OP2 or EXEC aborts the command; no response is ever issued for it.
- States: IDLE, OP2, EXEC.
- IDLE:
  - If cmd_in != 0 at the edge: latch cmd_in and data_in (op1), go to OP2, busy_out=1.
  - If cmd_in == 0: stay in IDLE.
- OP2:
  - Latch data_in as op2 at the next edge, regardless of cmd_in (protocol requires 0; nonzero is ignored).
  - Load the counter with LATENCY-1 and go to EXEC.
- EXEC:
  - Decrement the counter each edge.
  - On the edge where the counter is 0: register data_out/resp_out, clear busy_out, return to IDLE.
  - With LATENCY=1, the response registers on the first EXEC edge.
- Timing: op2 sampled at edge T -> response visible for exactly the one cycle following edge T+LATENCY; data_out=0 and resp_out=0 on all other cycles.
- In the response cycle the FSM is already in IDLE, so a command presented that cycle is accepted (back-to-back commands allowed).
- Commands presented while busy_out=1 are dropped silently, with no queueing and no response.
- Arithmetic, all unsigned, DATA_W bits:
  - cmd 1 add: op1+op2. Carry out -> resp 2, data 0; else resp 1, sum.
  - cmd 2 sub: op1-op2. If op2>op1 -> resp 2, data 0; else resp 1, difference (op1==op2 gives resp 1, data 0).
  - cmd 5 shl: op1 shifted left by op2 low 5 bits (data_in[27:31]), zero fill, resp 1. Upper op2 bits ignored; bits shifted out are lost (no overflow flag).
  - cmd 6 shr: logical right shift, same rules, resp 1.
  - Any other nonzero cmd: resp 3, data 0. Op2 is still consumed and the same latency applies.
- Overflow check uses a DATA_W+1 bit sum; results never wrap silently on add/sub.

Test Plan:
- Walking-one add: for k=0..30, cmd 1 with op1=1<<k, then op2=0 -> resp 1, data_out=1<<k, exactly LATENCY edges after op2, one cycle wide.
- Overflow: cmd 1 with op1=0xFFFFFFFF, op2=1 -> resp 2, data 0. Then cmd 1 with 0x7FFFFFFF+0x80000000 -> resp 1, 0xFFFFFFFF.
- Subtract: 6-5 -> resp 1, data 1. 5-5 -> resp 1, data 0. 5-6 -> resp 2, data 0.
- Shifts: op1=1 shl op2=33 -> data 2. op1=0x80000000 shr 31 -> data 1. op1=0xF shl 28 -> 0xF0000000. All resp 1.
- Invalid/busy: cmd 3 -> resp 3, data 0. Present cmd 1 during busy_out=1 -> ignored, only one response seen. Back-to-back cmd in the response cycle -> accepted and answered.
- Reset mid-op: assert reset for 1 cycle in EXEC -> outputs 0, no response. A following cmd 1 with 2+3 -> resp 1, data 5.
